// File: rtl/gb_irq_ctrl.sv
// gb_irq_ctrl: interrupt controller for the GB/GBC core.
//   Owns IF ($FF0F) and IE ($FFFF). Each source sets its IF bit either on a rising edge of a
//   level input or on a one-clock pulse. The controller drives the CPU INT_n line and supplies
//   the interrupt vector. The vector is latched when an ack starts, and that same latched index
//   picks the IF bit cleared when the ack ends, so the vector and the cleared bit always match.
// Ports:
//   clk      system clock, posedge only
//   reset    synchronous, active-high
//   irq_src  raw interrupt sources, bit 0 highest priority
//   sel_if   CPU address decodes to IF
//   sel_ie   CPU address decodes to IE
//   cpu_wr   CPU write strobe
//   cpu_di   CPU write data
//   cpu_do   read data, combinational while sel_if or sel_ie
//   irq_ack  CPU acknowledge cycle, level
//   irq_n    low while any enabled source is pending
//   irq_vec  vector for the current ack cycle
//   pending  IE & IF
module gb_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [7:0]  EDGE_MASK  = 8'h11,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter logic [7:0]  VEC_STRIDE = 8'h08,
  parameter logic [7:0]  NONE_VEC   = 8'h55
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               sel_if,
  input  logic               sel_ie,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  input  logic               irq_ack,
  output logic               irq_n,
  output logic [7:0]         irq_vec,
  output logic [NUM_IRQ-1:0] pending
);

  localparam int unsigned   IdxW    = 4;
  localparam logic [IdxW-1:0] IdxNone = IdxW'(NUM_IRQ);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] hist_q, hist_d;
  logic [NUM_IRQ-1:0] ev;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] if_wr_base;
  logic               ack_prev_q, ack_prev_d;
  logic               ack_rise, ack_fall;
  logic [IdxW-1:0]    ack_idx_q, ack_idx_d;
  logic [IdxW-1:0]    live_idx;
  logic [7:0]         rd_if, rd_ie;
  logic               unused_di;

  // Upper data bits are meaningless when fewer than 8 sources exist.
  assign unused_di = ^cpu_di;

  function automatic logic [7:0] vec_of(logic [IdxW-1:0] idx);
    logic [7:0] v;
    if (idx >= IdxNone) v = NONE_VEC;
    else                v = VEC_BASE + ({4'b0000, idx} * VEC_STRIDE);
    return v;
  endfunction

  always_comb begin
    pending = ie_q & if_q;
    irq_n   = ~|pending;
  end

  // Lowest-numbered pending source wins.
  always_comb begin
    live_idx = IdxNone;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending[i]) live_idx = IdxW'(i);
    end
  end

  assign ack_rise = irq_ack & ~ack_prev_q;
  assign ack_fall = ~irq_ack & ack_prev_q;

  always_comb begin
    ev      = '0;
    ack_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ev[i]      = EDGE_MASK[i] ? (irq_src[i] & ~hist_q[i]) : irq_src[i];
      // ack_idx_q == IdxNone never matches a real source, so an empty ack clears nothing.
      ack_clr[i] = ack_fall & (ack_idx_q == IdxW'(i));
    end
  end

  // Later terms win: CPU write, then ack clear, then hardware events.
  always_comb begin
    if_wr_base = (sel_if & cpu_wr) ? cpu_di[NUM_IRQ-1:0] : if_q;
    if_d       = (if_wr_base & ~ack_clr) | ev;
    ie_d       = (sel_ie & cpu_wr) ? cpu_di[NUM_IRQ-1:0] : ie_q;
    hist_d     = irq_src;
    ack_prev_d = irq_ack;
    ack_idx_d  = ack_rise ? live_idx : ack_idx_q;
  end

  // Frozen vector after the first ack cycle; live encode otherwise.
  always_comb begin
    irq_vec = (irq_ack & ack_prev_q) ? vec_of(ack_idx_q) : vec_of(live_idx);
  end

  always_comb begin
    rd_if = 8'hFF;
    rd_ie = 8'h00;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      rd_if[i] = if_q[i];
      rd_ie[i] = ie_q[i];
    end
    if (sel_if)      cpu_do = rd_if;
    else if (sel_ie) cpu_do = rd_ie;
    else             cpu_do = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q       <= '0;
      ie_q       <= '0;
      // Load history so a level already high at release is not seen as an edge.
      hist_q     <= irq_src;
      ack_prev_q <= 1'b0;
      ack_idx_q  <= IdxNone;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      hist_q     <= hist_d;
      ack_prev_q <= ack_prev_d;
      ack_idx_q  <= ack_idx_d;
    end
  end

endmodule

// File: tb/tb_gb_irq_ctrl.sv
module tb_gb_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: default 5-source map. DUT b: 8 sources, base 0, stride 0x20.
  logic [4:0] a_src = '0;
  logic       a_sel_if = 0, a_sel_ie = 0, a_wr = 0, a_ack = 0;
  logic [7:0] a_di = '0;
  logic [7:0] a_do, a_vec;
  logic       a_irq_n;
  logic [4:0] a_pend;

  logic [7:0] b_src = '0;
  logic       b_sel_if = 0, b_sel_ie = 0, b_wr = 0, b_ack = 0;
  logic [7:0] b_di = '0;
  logic [7:0] b_do, b_vec;
  logic       b_irq_n;
  logic [7:0] b_pend;

  gb_irq_ctrl u_a (
    .clk(clk), .reset(rst), .irq_src(a_src), .sel_if(a_sel_if), .sel_ie(a_sel_ie),
    .cpu_wr(a_wr), .cpu_di(a_di), .cpu_do(a_do), .irq_ack(a_ack), .irq_n(a_irq_n),
    .irq_vec(a_vec), .pending(a_pend)
  );

  gb_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(8'h00), .VEC_STRIDE(8'h20)) u_b (
    .clk(clk), .reset(rst), .irq_src(b_src), .sel_if(b_sel_if), .sel_ie(b_sel_ie),
    .cpu_wr(b_wr), .cpu_di(b_di), .cpu_do(b_do), .irq_ack(b_ack), .irq_n(b_irq_n),
    .irq_vec(b_vec), .pending(b_pend)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_if[2], m_ie[2], m_hist[2], m_ackd[2], m_idx[2];

  function automatic int unsigned num(input int k);   return k ? 8 : 5; endfunction
  function automatic int unsigned vbase(input int k); return k ? 0 : 'h40; endfunction
  function automatic int unsigned vstr(input int k);  return k ? 'h20 : 8; endfunction

  function automatic int unsigned lowest(input int unsigned v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) if ((v >> i) & 1) return i;
    return n;
  endfunction

  function automatic int unsigned vecf(input int k, input int unsigned idx);
    if (idx >= num(k)) return 'h55;
    return (vbase(k) + idx * vstr(k)) % 256;
  endfunction

  task automatic mstep(input int k, input bit r, input int unsigned src, input bit sif,
                       input bit sie, input bit wr, input int unsigned di, input bit ack);
    int unsigned n, full, ev, clr, nif, nie;
    n    = num(k);
    full = (1 << n) - 1;
    if (r) begin
      m_if[k] = 0; m_ie[k] = 0; m_hist[k] = src; m_ackd[k] = 0; m_idx[k] = n;
    end else begin
      ev = 0;
      for (int unsigned i = 0; i < n; i++) begin
        if (('h11 >> i) & 1) ev |= (((src >> i) & 1) & ~((m_hist[k] >> i) & 1)) << i;
        else                 ev |= ((src >> i) & 1) << i;
      end
      clr = (!ack && m_ackd[k] != 0 && m_idx[k] < n) ? (1 << m_idx[k]) : 0;
      nif = (((sif && wr) ? (di & full) : m_if[k]) & ~clr | ev) & full;
      nie = (sie && wr) ? (di & full) : m_ie[k];
      if (ack && m_ackd[k] == 0) m_idx[k] = lowest(m_if[k] & m_ie[k], n);
      m_ackd[k] = ack; m_hist[k] = src; m_if[k] = nif; m_ie[k] = nie;
    end
  endtask

  always @(posedge clk) begin
    mstep(0, rst, a_src, a_sel_if, a_sel_ie, a_wr, a_di, a_ack);
    mstep(1, rst, b_src, b_sel_if, b_sel_ie, b_wr, b_di, b_ack);
  end

  task automatic mcheck(input int k, input logic [7:0] dout, input logic irqn,
                        input logic [7:0] vec, input logic [7:0] pend, input bit sif,
                        input bit sie, input bit ack);
    int unsigned full, p, ev_do, ev_vec;
    full  = (1 << num(k)) - 1;
    p     = m_if[k] & m_ie[k];
    ev_do = sif ? ((m_if[k] | ~full) & 'hFF) : (sie ? m_ie[k] : 'hFF);
    ev_vec = (ack && m_ackd[k] != 0) ? vecf(k, m_idx[k]) : vecf(k, lowest(p, num(k)));
    chk(k ? "b_pending" : "a_pending", {24'h0, pend}, p);
    chk(k ? "b_irq_n" : "a_irq_n", {31'h0, irqn}, (p == 0) ? 1 : 0);
    chk(k ? "b_irq_vec" : "a_irq_vec", {24'h0, vec}, ev_vec);
    chk(k ? "b_cpu_do" : "a_cpu_do", {24'h0, dout}, ev_do);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mcheck(0, a_do, a_irq_n, a_vec, {3'b000, a_pend}, a_sel_if, a_sel_ie, a_ack);
      mcheck(1, b_do, b_irq_n, b_vec, b_pend, b_sel_if, b_sel_ie, b_ack);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic a_write(input bit to_if, input logic [7:0] d);
    a_sel_if = to_if; a_sel_ie = !to_if; a_wr = 1; a_di = d;
    tick;
    a_sel_if = 0; a_sel_ie = 0; a_wr = 0;
  endtask

  task automatic a_read_if(input string name, input logic [7:0] exp);
    a_sel_if = 1; #1;
    chk(name, {24'h0, a_do}, {24'h0, exp});
    a_sel_if = 0; #1;
  endtask

  initial begin
    // 1: level held through reset is not an event
    rst = 1; a_src = 5'h01;
    tick; chk_en = 1; tick;
    rst = 0; tick;
    a_write(0, 8'h01); tick;
    chk("t1_irq_n_idle", {31'h0, a_irq_n}, 1);
    a_read_if("t1_if_zero", 8'hE0);
    a_src = 5'h00; tick;
    a_src = 5'h01; tick;
    chk("t1_irq_n_low", {31'h0, a_irq_n}, 0);
    chk("t1_model_if", m_if[0], 1);
    a_write(1, 8'h00); a_src = 5'h00; tick;

    // 2: vector frozen across a 3-cycle ack, cleared bit matches
    a_write(0, 8'h1F);
    a_src = 5'h04; tick;
    a_src = 5'h10; tick;
    a_read_if("t2_if_f4", 8'hF4);
    a_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t2_vec_50", {24'h0, a_vec}, 32'h50);
    end
    a_ack = 0; tick;
    a_read_if("t2_if_f0", 8'hF0);
    a_write(1, 8'h00); a_src = 5'h00; tick;

    // 3: higher-priority arrival mid-ack is not cleared
    a_write(1, 8'h08);
    a_ack = 1; tick;
    chk("t3_vec_first", {24'h0, a_vec}, 32'h58);
    a_src = 5'h01; tick;
    chk("t3_vec_held", {24'h0, a_vec}, 32'h58);
    a_ack = 0; tick;
    a_read_if("t3_if_e1", 8'hE1);
    chk("t3_irq_n", {31'h0, a_irq_n}, 0);
    a_src = 5'h00; a_write(1, 8'h00); tick;

    // 4: event beats a CPU write of zero; disabled source keeps irq_n high
    a_src = 5'h02; a_write(1, 8'h00); a_src = 5'h00;
    a_read_if("t4_if_e2", 8'hE2);
    a_write(0, 8'h00);
    a_write(1, 8'h04); tick;
    chk("t4_irq_n_hi", {31'h0, a_irq_n}, 1);

    // 5: empty ack, IE read-back width
    a_ack = 1; tick;
    chk("t5_vec_none", {24'h0, a_vec}, 32'h55);
    a_ack = 0; tick;
    a_read_if("t5_if_e4", 8'hE4);
    a_write(0, 8'hFF);
    a_sel_ie = 1; #1;
    chk("t5_ie_1f", {24'h0, a_do}, 32'h1F);
    a_sel_ie = 0; tick;

    // 6: 8-source instance, vector wrap map
    b_sel_ie = 1; b_wr = 1; b_di = 8'h80; tick;
    b_sel_ie = 0; b_wr = 0;
    b_src = 8'h80; tick; b_src = 8'h00;
    b_sel_if = 1; #1;
    chk("t6_if_80", {24'h0, b_do}, 32'h80);
    b_sel_if = 0;
    b_ack = 1; tick;
    chk("t6_vec_e0", {24'h0, b_vec}, 32'hE0);
    b_ack = 0; tick;

    // random phase, including occasional reset mid-ack
    for (int c = 0; c < 3000; c++) begin
      int unsigned s;
      rst   = ($urandom_range(0, 199) == 0);
      a_src = 5'($urandom);
      b_src = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a_ack = !a_ack;
      if ($urandom_range(0, 3) == 0) b_ack = !b_ack;
      s = $urandom_range(0, 2);
      a_sel_if = (s == 1); a_sel_ie = (s == 2);
      a_wr = ($urandom_range(0, 3) == 0); a_di = 8'($urandom);
      s = $urandom_range(0, 2);
      b_sel_if = (s == 1); b_sel_ie = (s == 2);
      b_wr = ($urandom_range(0, 3) == 0); b_di = 8'($urandom);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
